rle_memory_writer: RTL
======================

// Module: rle_memory_writer
// PURPOSE
// - Write-side counterpart of the memory reader: accepts a run-length-encoded byte stream (data + repeat count) over a valid/ready handshake.
// - Expands each run and writes it sequentially into the single-port CPU_MEM SRAM (csb0/web0/addr0/din0).
// - Sits between an upstream producer (CPU/loader) and CPU_MEM; reports done, words written and overflow.
// PARAMETERS
// - ADDR_WIDTH  8     SRAM address width; depth = 2**ADDR_WIDTH
// - DATA_WIDTH  8     SRAM/stream data width
// - CNT_WIDTH   8     repeats_in width
// - BASE_ADDR   0     first address written after start
// PORTS
// - clk            in   1             single clock, all logic on rising edge
// - resetn         in   1             asynchronous active-low reset
// - start          in   1             1-cycle pulse, begins a write session (honoured only in IDLE)
// - data_in        in   DATA_WIDTH    run value
// - repeats_in     in   CNT_WIDTH     run length; 0 = consume pair, no write
// - last_in        in   1             pair is final run of the session
// - valid          in   1             upstream pair valid
// - ready          out  1             writer can accept a pair
// - done           out  1             1-cycle pulse at session end
// - overflow       out  1             memory filled before stream finished; holds until next start
// - words_written  out  ADDR_WIDTH+1  writes performed this session; holds until next start
// - csb0           out  1             SRAM chip select, active low
// - web0           out  1             SRAM write enable, active low (never high while csb0=0)
// - addr0          out  ADDR_WIDTH    SRAM address
// - din0           out  DATA_WIDTH    SRAM write data
// - checksum       out  DATA_WIDTH    only with WRITER_CHECKSUM_EN
// BEHAVIOUR
// - Reset: state IDLE; ready=0, done=0, overflow=0, words_written=0, csb0=1, web0=1, addr0=0, din0=0, checksum=0.
// - States: IDLE, ACCEPT, WRITE, DONE. Outputs decode from registered state/regs; no comb path from valid to ready.
// - IDLE: start=1 -> ACCEPT; ptr=BASE_ADDR, words_written=0, overflow=0, checksum=0.
// - ACCEPT: ready=1, csb0=1. On valid&&ready: latch data, cnt=repeats_in, last.
//   - repeats_in=0: no write; last_in=1 -> DONE, else stay ACCEPT.
//   - else -> WRITE.
// - WRITE: ready=0; csb0=0, web0=0, addr0=ptr, din0=data_reg. Each edge: one SRAM write; ptr+1, cnt-1, words_written+1.
//   - cnt=1 and last_reg=1 -> DONE. cnt=1 and last_reg=0 -> ACCEPT.
//   - ptr=2**ADDR_WIDTH-1 and the run or the session is unfinished -> overflow=1, DONE. Remaining writes dropped; ptr never wraps to 0.
//   - Memory-full check takes priority over the cnt=1 check, except when cnt=1 and last_reg=1 (clean finish, overflow=0).
// - DONE: done=1 for exactly one cycle, csb0=1, ready=0 -> IDLE.
// - Latency: a pair accepted at edge N is written at edges N+1 .. N+repeats. A run of R costs R+1 cycles including the accept cycle.
// - Ignored inputs: start outside IDLE; valid outside ACCEPT. Upstream must hold a pair stable until the handshake completes.
// - Async reset mid-session: csb0/web0 deassert immediately, the session is discarded, state is IDLE. Already-written SRAM contents are kept.
// CONFIGURATION
// - WRITER_CHECKSUM_EN defined: port checksum exists.
//   - checksum = modulo-2**DATA_WIDTH sum of every byte written this session.
//   - Updated on each write edge, cleared on start, held after done.
// - WRITER_CHECKSUM_EN undefined: no checksum port and no adder logic; all other behaviour identical.
// TESTING
// - start; (0xAA,3,0),(0x55,2,1) -> mem[0..2]=AA, mem[3..4]=55, one done pulse, words_written=5, overflow=0.
// - start; (0x11,0,0),(0x22,1,1) -> only mem[0]=22 written, words_written=1, no write cycle for the 0x11 pair.
// - Randomised valid gaps, 4 pairs -> ready high only in ACCEPT; csb0=1 throughout ACCEPT.
//   - Expected writes = sum of repeats; addresses contiguous from BASE_ADDR.
// - BASE_ADDR=0xFE; (0x77,5,1) -> mem[FE],mem[FF]=77, overflow=1, words_written=2, done pulse, no write to 0x00.
// - resetn low after 2 of 4 writes -> csb0=1, ready=0 immediately. Next start writes again from BASE_ADDR with words_written reset.
// - WRITER_CHECKSUM_EN, first scenario -> checksum=0xA8 after done; start clears it to 0x00.

Source files
------------

// File: rtl/rle_memory_writer.sv
// rle_memory_writer: expands a run-length-encoded byte stream (value + repeat
// count, valid/ready handshake) into sequential writes to a single-port SRAM.
// Reports a one-cycle done pulse, the number of words written this session and
// a sticky overflow flag when the memory fills before the stream finishes.
// Optional feature macro: WRITER_CHECKSUM_EN adds a running byte-sum output.
module rle_memory_writer #(
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    DATA_WIDTH = 8,
  parameter int                    CNT_WIDTH  = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [CNT_WIDTH-1:0]  repeats_in,
  input  logic                  last_in,
  input  logic                  valid,
  output logic                  ready,
  output logic                  done,
  output logic                  overflow,
  output logic [ADDR_WIDTH:0]   words_written,
  output logic                  csb0,
  output logic                  web0,
  output logic [ADDR_WIDTH-1:0] addr0,
`ifdef WRITER_CHECKSUM_EN
  output logic [DATA_WIDTH-1:0] checksum,
`endif
  output logic [DATA_WIDTH-1:0] din0
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCEPT = 2'd1,
    S_WRITE  = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] LP_PTR_MAX = '1;
  localparam logic [CNT_WIDTH-1:0]  LP_CNT_ONE = CNT_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   LP_WW_ONE  = (ADDR_WIDTH+1)'(1);

  state_t                  r_state;
  logic                    r_ready;
  logic                    r_done;
  logic                    r_overflow;
  logic [ADDR_WIDTH:0]     r_words;
  logic                    r_csb0;
  logic                    r_web0;
  logic [ADDR_WIDTH-1:0]   r_ptr;
  logic [DATA_WIDTH-1:0]   r_data;
  logic [CNT_WIDTH-1:0]    r_cnt;
  logic                    r_last;

  logic w_accept;
  logic w_run_end;
  logic w_mem_full;

  // Handshake completes only while the registered ready is up, so valid never
  // reaches ready combinationally.
  assign w_accept   = r_ready && valid;
  assign w_run_end  = (r_cnt == LP_CNT_ONE);
  assign w_mem_full = (r_ptr == LP_PTR_MAX);

  assign ready         = r_ready;
  assign done          = r_done;
  assign overflow      = r_overflow;
  assign words_written = r_words;
  assign csb0          = r_csb0;
  assign web0          = r_web0;
  assign addr0         = r_ptr;
  assign din0          = r_data;

  // Session FSM: every output is a register set on the transition into the
  // state that owns it, so the SRAM strobes are glitch-free.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state    <= S_IDLE;
      r_ready    <= 1'b0;
      r_done     <= 1'b0;
      r_overflow <= 1'b0;
      r_words    <= '0;
      r_csb0     <= 1'b1;
      r_web0     <= 1'b1;
      r_ptr      <= '0;
      r_data     <= '0;
      r_cnt      <= '0;
      r_last     <= 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state    <= S_ACCEPT;
            r_ready    <= 1'b1;
            r_ptr      <= BASE_ADDR;
            r_words    <= '0;
            r_overflow <= 1'b0;
          end
        end
        S_ACCEPT: begin
          if (w_accept) begin
            r_data  <= data_in;
            r_cnt   <= repeats_in;
            r_last  <= last_in;
            if (repeats_in == '0) begin
              // Empty run: consumed without touching the SRAM.
              if (last_in) begin
                r_state <= S_DONE;
                r_ready <= 1'b0;
                r_done  <= 1'b1;
              end
            end else begin
              r_state <= S_WRITE;
              r_ready <= 1'b0;
              r_csb0  <= 1'b0;
              r_web0  <= 1'b0;
            end
          end
        end
        S_WRITE: begin
          // One SRAM write lands on this edge at r_ptr.
          r_words <= r_words + LP_WW_ONE;
          r_cnt   <= r_cnt - LP_CNT_ONE;
          if (w_run_end && r_last) begin
            // Clean finish wins even if the final write hit the top address.
            r_state <= S_DONE;
            r_csb0  <= 1'b1;
            r_web0  <= 1'b1;
            r_done  <= 1'b1;
          end else if (w_mem_full) begin
            // Out of memory with work remaining: drop the rest, never wrap.
            r_state    <= S_DONE;
            r_csb0     <= 1'b1;
            r_web0     <= 1'b1;
            r_done     <= 1'b1;
            r_overflow <= 1'b1;
          end else if (w_run_end) begin
            r_state <= S_ACCEPT;
            r_csb0  <= 1'b1;
            r_web0  <= 1'b1;
            r_ready <= 1'b1;
            r_ptr   <= r_ptr + 1'b1;
          end else begin
            r_ptr   <= r_ptr + 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef WRITER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_checksum;

  assign checksum = r_checksum;

  // Running modulo sum of every byte written; cleared on start, held after done.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_checksum <= '0;
    end else if (r_state == S_IDLE && start) begin
      r_checksum <= '0;
    end else if (r_state == S_WRITE) begin
      r_checksum <= r_checksum + r_data;
    end
  end
`endif

endmodule
